p_mac: RTL

P_MAC -- requirements
Module: p_mac

---
 rtl/p_mac.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/p_mac.sv
// p_mac: packed-lane multiply / multiply-accumulate.
// Operands are split into XLEN/w unsigned lanes, where pw selects the width w.
// Each lane forms its 2w-bit product (integer or carry-less) with one shift-add
// step per cycle, so latency follows the lane width. The low or high half is then
// selected and crs3 is optionally accumulated into it.
module p_mac #(
    parameter int XLEN = 32,
    parameter int PWW  = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid,
    output logic            ready,
    input  logic            mul_l,
    input  logic            mul_h,
    input  logic            clmul,
    input  logic            acc,
    input  logic [PWW-1:0]  pw,
    input  logic [XLEN-1:0] crs1,
    input  logic [XLEN-1:0] crs2,
    input  logic [XLEN-1:0] crs3,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam int KW = (PWW > 1) ? $clog2(PWW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [KW-1:0]    r_k;          // width index: w = XLEN >> r_k
    logic [CW-1:0]    r_cnt;        // step counter inside RUN
    logic [2*XLEN-1:0] r_ae;        // multiplicand lanes, zero-extended to 2w, shifted left per step
    logic [XLEN-1:0]  r_b;          // multiplier, shifted right per step; lane bit j sits at lane LSB
    logic [XLEN-1:0]  r_c;          // accumuland
    logic [2*XLEN-1:0] r_p;         // partial products, 2w bits per lane
    logic             r_clmul, r_acc, r_hi;
    logic [XLEN-1:0]  r_result;

    logic             w_pw_onehot;
    logic [KW-1:0]    w_k_in;
    logic [CW-1:0]    w_wm1;
    logic             w_last;
    logic [2*XLEN-1:0] w_spread_k [PWW];
    logic [2*XLEN-1:0] w_add_k    [PWW];
    logic [XLEN-1:0]  w_res_k    [PWW];

    assign w_pw_onehot = (pw != '0) && ((pw & (pw - 1'b1)) == '0);
    assign w_wm1       = CW'((XLEN >> r_k) - 1);
    assign w_last      = (r_cnt == w_wm1);
    assign result      = r_result;

    // Decode the incoming pw to a width index; anything not one-hot means full width.
    always_comb begin
        w_k_in = '0;
        if (w_pw_onehot) begin
            for (int i = 0; i < PWW; i++) begin
                if (pw[i]) w_k_in = KW'(i);
            end
        end
    end

    // One lane layout per supported width; the captured index picks which one is live.
    for (genvar gk = 0; gk < PWW; gk++) begin : g_width
        localparam int W  = XLEN >> gk;
        localparam int NL = XLEN / W;

        logic [2*XLEN-1:0] w_spread;
        logic [2*XLEN-1:0] w_add;
        logic [XLEN-1:0]   w_res;

        // Lane spreading, one shift-add/XOR step, and half-select plus accumulate.
        always_comb begin
            w_spread = '0;
            w_add    = '0;
            w_res    = '0;
            for (int l = 0; l < NL; l++) begin
                w_spread[2*W*l +: 2*W] = {{W{1'b0}}, crs1[W*l +: W]};
                if (r_clmul)
                    w_add[2*W*l +: 2*W] = r_p[2*W*l +: 2*W] ^ (r_b[W*l] ? r_ae[2*W*l +: 2*W] : '0);
                else
                    w_add[2*W*l +: 2*W] = r_p[2*W*l +: 2*W] + (r_b[W*l] ? r_ae[2*W*l +: 2*W] : '0);
                if (r_clmul)
                    w_res[W*l +: W] = (r_hi ? w_add[2*W*l+W +: W] : w_add[2*W*l +: W])
                                    ^ (r_acc ? r_c[W*l +: W] : '0);
                else
                    w_res[W*l +: W] = (r_hi ? w_add[2*W*l+W +: W] : w_add[2*W*l +: W])
                                    + (r_acc ? r_c[W*l +: W] : '0);
            end
        end

        assign w_spread_k[gk] = w_spread;
        assign w_add_k[gk]    = w_add;
        assign w_res_k[gk]    = w_res;
    end

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking (<=) so every flop samples pre-edge values and ordering between blocks cannot matter.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic: a dropped valid during RUN aborts, DONE always returns to IDLE.
    always_comb begin
        // NOTE: default first, so every path assigns the signal and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (valid) w_state_nxt = S_RUN;
            S_RUN: begin
                if (!valid)      w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: ready marks the single DONE cycle.
    always_comb begin
        ready = (r_state == S_DONE);
    end

    // Datapath: capture on acceptance, step each RUN cycle, register the result on the last step.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_k      <= '0;
            r_cnt    <= '0;
            r_ae     <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_p      <= '0;
            r_clmul  <= 1'b0;
            r_acc    <= 1'b0;
            r_hi     <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_k     <= w_k_in;
                        r_cnt   <= '0;
                        r_ae    <= w_spread_k[w_k_in];
                        r_b     <= crs2;
                        r_c     <= crs3;
                        r_p     <= '0;
                        r_clmul <= clmul;
                        r_acc   <= acc;
                        // mul_h wins; with neither half requested the high half is returned.
                        r_hi    <= mul_h | ~mul_l;
                    end
                end
                S_RUN: begin
                    if (valid) begin
                        r_p   <= w_add_k[r_k];
                        r_ae  <= r_ae << 1;
                        r_b   <= r_b >> 1;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) r_result <= w_res_k[r_k];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
